// File: rtl/alu_exec_pipe_if.sv
// alu_exec_pipe_if: issue, PRF read and writeback signals of the ALU execution pipe
interface alu_exec_pipe_if #(
  parameter int PHYS_REG_BITS = 7,
  parameter int ROB_TAG_BITS  = 4,
  parameter int XLEN          = 32
);
  logic                     issue_en;
  logic                     eu_ready;
  logic [PHYS_REG_BITS-1:0] issue_prs1;
  logic [PHYS_REG_BITS-1:0] issue_prs2;
  logic [PHYS_REG_BITS-1:0] issue_prd;
  logic [ROB_TAG_BITS-1:0]  issue_rob_tag;
  logic [XLEN-1:0]          issue_pc;
  logic [XLEN-1:0]          issue_imm;
  logic                     issue_alu_src;
  logic [3:0]               issue_alu_ctrl;
  logic                     issue_reg_write;
  logic [PHYS_REG_BITS-1:0] prf_raddr1;
  logic [PHYS_REG_BITS-1:0] prf_raddr2;
  logic [XLEN-1:0]          prf_rdata1;
  logic [XLEN-1:0]          prf_rdata2;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [PHYS_REG_BITS-1:0] wb_prd;
  logic [XLEN-1:0]          wb_data;
  logic [ROB_TAG_BITS-1:0]  wb_rob_tag;
  logic                     wb_reg_write;
  logic                     wb_en;
  logic                     flush;
  modport master (
    output issue_en, issue_prs1, issue_prs2, issue_prd, issue_rob_tag, issue_pc, issue_imm,
           issue_alu_src, issue_alu_ctrl, issue_reg_write, prf_rdata1, prf_rdata2, wb_ready, flush,
    input  eu_ready, prf_raddr1, prf_raddr2, wb_valid, wb_prd, wb_data, wb_rob_tag, wb_reg_write, wb_en
  );
  modport slave (
    input  issue_en, issue_prs1, issue_prs2, issue_prd, issue_rob_tag, issue_pc, issue_imm,
           issue_alu_src, issue_alu_ctrl, issue_reg_write, prf_rdata1, prf_rdata2, wb_ready, flush,
    output eu_ready, prf_raddr1, prf_raddr2, wb_valid, wb_prd, wb_data, wb_rob_tag, wb_reg_write, wb_en
  );
endinterface

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: 3-stage (RR, EX, WB) integer execution unit with issue and writeback handshakes
module alu_exec_pipe #(
  parameter int PHYS_REG_BITS = 7,
  parameter int ROB_TAG_BITS  = 4,
  parameter int XLEN          = 32
) (
  input logic           clk,
  input logic           rst_n,
  alu_exec_pipe_if.slave bus
);
  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [ROB_TAG_BITS-1:0]  tag;
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          imm;
    logic                     src;
    logic [3:0]               ctrl;
    logic                     rw;
  } rr_t;
  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] prd;
    logic [ROB_TAG_BITS-1:0]  tag;
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          imm;
    logic                     src;
    logic [3:0]               ctrl;
    logic                     rw;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          rs2;
  } ex_t;
  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] prd;
    logic [XLEN-1:0]          data;
    logic [ROB_TAG_BITS-1:0]  tag;
    logic                     rw;
  } wb_t;
  logic rr_v_q, rr_v_d, ex_v_q, ex_v_d, wb_v_q, wb_v_d;
  rr_t rr_q, rr_d, issue;
  ex_t ex_q, ex_d;
  wb_t wb_q, wb_d;
  logic adv_wb, adv_ex, adv_rr, accept;
  logic [XLEN-1:0] op_b, alu_res;
  logic [4:0] shamt;
  assign adv_wb = ~wb_v_q | bus.wb_ready;
  assign adv_ex = ~ex_v_q | adv_wb;
  assign adv_rr = ~rr_v_q | adv_ex;
  assign bus.eu_ready = adv_rr & ~bus.flush;
  assign accept = bus.issue_en & bus.eu_ready;
  assign issue = '{prs1: bus.issue_prs1, prs2: bus.issue_prs2, prd: bus.issue_prd,
                   tag: bus.issue_rob_tag, pc: bus.issue_pc, imm: bus.issue_imm,
                   src: bus.issue_alu_src, ctrl: bus.issue_alu_ctrl, rw: bus.issue_reg_write};
  assign op_b  = ex_q.src ? ex_q.imm : ex_q.rs2;
  assign shamt = op_b[4:0];
  always_comb begin
    alu_res = '0;
    case (ex_q.ctrl)
      4'd0:  alu_res = ex_q.rs1 + op_b;
      4'd1:  alu_res = ex_q.rs1 - op_b;
      4'd2:  alu_res = ex_q.rs1 << shamt;
      4'd3:  alu_res = XLEN'($signed(ex_q.rs1) < $signed(op_b));
      4'd4:  alu_res = XLEN'(ex_q.rs1 < op_b);
      4'd5:  alu_res = ex_q.rs1 ^ op_b;
      4'd6:  alu_res = ex_q.rs1 >> shamt;
      4'd7:  alu_res = $signed(ex_q.rs1) >>> shamt;
      4'd8:  alu_res = ex_q.rs1 | op_b;
      4'd9:  alu_res = ex_q.rs1 & op_b;
      4'd10: alu_res = op_b;
      4'd11: alu_res = ex_q.pc + ex_q.imm;
      default: alu_res = '0;
    endcase
  end
  // Flush wins over advance; a stage that moves on with nothing behind it takes a bubble.
  always_comb begin
    rr_v_d = bus.flush ? 1'b0 : adv_rr ? bus.issue_en : rr_v_q;
    ex_v_d = bus.flush ? 1'b0 : adv_ex ? rr_v_q : ex_v_q;
    wb_v_d = bus.flush ? 1'b0 : adv_wb ? ex_v_q : wb_v_q;
    rr_d   = accept ? issue : rr_q;
    ex_d   = (adv_ex & rr_v_q)
           ? '{prd: rr_q.prd, tag: rr_q.tag, pc: rr_q.pc, imm: rr_q.imm, src: rr_q.src,
               ctrl: rr_q.ctrl, rw: rr_q.rw, rs1: bus.prf_rdata1, rs2: bus.prf_rdata2}
           : ex_q;
    wb_d   = (adv_wb & ex_v_q)
           ? '{prd: ex_q.prd, data: alu_res, tag: ex_q.tag, rw: ex_q.rw & (|ex_q.prd)}
           : wb_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_v_q <= 1'b0;
      ex_v_q <= 1'b0;
      wb_v_q <= 1'b0;
      rr_q   <= '0;
      ex_q   <= '0;
      wb_q   <= '0;
    end else begin
      rr_v_q <= rr_v_d;
      ex_v_q <= ex_v_d;
      wb_v_q <= wb_v_d;
      rr_q   <= rr_d;
      ex_q   <= ex_d;
      wb_q   <= wb_d;
    end
  end
  assign bus.prf_raddr1   = rr_q.prs1;
  assign bus.prf_raddr2   = rr_q.prs2;
  assign bus.wb_valid     = wb_v_q;
  assign bus.wb_prd       = wb_q.prd;
  assign bus.wb_data      = wb_q.data;
  assign bus.wb_rob_tag   = wb_q.tag;
  assign bus.wb_reg_write = wb_q.rw;
  assign bus.wb_en        = wb_v_q & bus.wb_ready;
endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb_alu_exec_pipe: scoreboarded random and directed checks of alu_exec_pipe
module tb_alu_exec_pipe;
  localparam int P = 7;
  localparam int T = 4;
  localparam int X = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_exec_pipe_if #(.PHYS_REG_BITS(P), .ROB_TAG_BITS(T), .XLEN(X)) bus();
  alu_exec_pipe #(.PHYS_REG_BITS(P), .ROB_TAG_BITS(T), .XLEN(X)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [X-1:0] prf [0:(1<<P)-1];
  assign bus.prf_rdata1 = prf[bus.prf_raddr1];
  assign bus.prf_rdata2 = prf[bus.prf_raddr2];
  typedef struct {
    logic [P-1:0] prd;
    logic [X-1:0] data;
    logic [T-1:0] tag;
    logic         rw;
  } res_t;
  res_t q[$];
  int checks = 0;
  int errors = 0;
  logic exp_rdy;
  function automatic logic [X-1:0] ref_alu(input logic [3:0] op, input logic [X-1:0] a, input logic [X-1:0] rs2,
                                           input logic [X-1:0] imm, input logic [X-1:0] pc, input logic src);
    logic [X-1:0] b;
    b = src ? imm : rs2;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << b[4:0];
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> b[4:0];
      4'd7:  return $signed(a) >>> b[4:0];
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      4'd11: return pc + imm;
      default: return '0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Scoreboard: the pipe holds at most 3 results; a new one fits if any slot is free or the oldest leaves.
  always @(negedge clk) if (rst_n) begin
    exp_rdy = !bus.flush && (q.size() < 3 || bus.wb_ready);
    chk("eu_ready", bus.eu_ready, exp_rdy);
    chk("wb_en", bus.wb_en, bus.wb_valid & bus.wb_ready);
    if (bus.wb_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 prd=%0h data=%0h required no result pending", bus.wb_prd, bus.wb_data);
      end else begin
        chk("wb_prd", bus.wb_prd, q[0].prd);
        chk("wb_data", bus.wb_data, q[0].data);
        chk("wb_rob_tag", bus.wb_rob_tag, q[0].tag);
        chk("wb_reg_write", bus.wb_reg_write, q[0].rw);
      end
    end
    if (bus.wb_valid && bus.wb_ready && q.size() > 0) void'(q.pop_front());
    if (bus.flush) q.delete();
    else if (bus.issue_en && exp_rdy)
      q.push_back('{prd: bus.issue_prd,
                    data: ref_alu(bus.issue_alu_ctrl, prf[bus.issue_prs1], prf[bus.issue_prs2],
                                  bus.issue_imm, bus.issue_pc, bus.issue_alu_src),
                    tag: bus.issue_rob_tag,
                    rw: bus.issue_reg_write && bus.issue_prd != 0});
  end
  always @(negedge rst_n) q.delete();
  task automatic issue(input logic [3:0] c, input logic [P-1:0] s1, input logic [P-1:0] s2, input logic [P-1:0] d,
                       input logic [T-1:0] t, input logic [X-1:0] pc, input logic [X-1:0] imm, input logic src, input logic rw);
    logic ok;
    int n;
    bus.issue_alu_ctrl = c; bus.issue_prs1 = s1; bus.issue_prs2 = s2; bus.issue_prd = d;
    bus.issue_rob_tag = t; bus.issue_pc = pc; bus.issue_imm = imm; bus.issue_alu_src = src;
    bus.issue_reg_write = rw; bus.issue_en = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = bus.eu_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got eu_ready=0 for %0d cycles required acceptance", n);
    end
  endtask
  task automatic rand_fields();
    bus.issue_prs1 = P'($urandom); bus.issue_prs2 = P'($urandom);
    bus.issue_prd = ($urandom_range(0, 7) == 0) ? '0 : P'($urandom);
    bus.issue_rob_tag = T'($urandom); bus.issue_pc = $urandom; bus.issue_imm = $urandom;
    bus.issue_alu_src = 1'($urandom); bus.issue_alu_ctrl = 4'($urandom); bus.issue_reg_write = 1'($urandom);
  endtask
  task automatic rand_issue();
    rand_fields();
    issue(bus.issue_alu_ctrl, bus.issue_prs1, bus.issue_prs2, bus.issue_prd, bus.issue_rob_tag,
          bus.issue_pc, bus.issue_imm, bus.issue_alu_src, bus.issue_reg_write);
  endtask
  task automatic lat_check(input string name);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(name, bus.wb_valid, (k == 2));
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [X-1:0] got[$];
    logic [X-1:0] snap;
    int first, last, acc;
    for (int i = 0; i < (1 << P); i++) prf[i] = $urandom;
    prf[5] = 32'h10; prf[6] = 32'h22; prf[8] = 32'hFFFFFFFF; prf[9] = 32'h1; prf[10] = 32'h80000000;
    bus.issue_en = 1'b0; bus.flush = 1'b0; bus.wb_ready = 1'b1;
    rand_fields();
    #12;
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_wb_fields", {bus.wb_prd, bus.wb_data, bus.wb_rob_tag, bus.wb_reg_write}, 0);
    chk("rst_raddr", {bus.prf_raddr1, bus.prf_raddr2}, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("eu_ready_after_rst", bus.eu_ready, 1);
    // single ADD
    issue(4'd0, 7'd5, 7'd6, 7'd40, 4'd3, 0, 0, 1'b0, 1'b1);
    bus.issue_en = 1'b0;
    lat_check("single_latency");
    chk("single_data", bus.wb_data, 32'h32);
    chk("single_prd", bus.wb_prd, 40);
    chk("single_tag", bus.wb_rob_tag, 3);
    chk("single_wb_en", bus.wb_en, 1);
    @(negedge clk);
    chk("single_wb_en_pulse", bus.wb_en, 0);
    @(posedge clk); #1;
    // back-to-back
    first = -1; last = -1;
    fork
      begin
        issue(4'd1, 7'd6, 7'd5, 7'd41, 4'd4, 0, 0, 1'b0, 1'b1);
        issue(4'd3, 7'd8, 7'd9, 7'd42, 4'd5, 0, 0, 1'b0, 1'b1);
        issue(4'd7, 7'd10, 7'd1, 7'd43, 4'd6, 0, 32'd4, 1'b1, 1'b1);
        issue(4'd11, 7'd1, 7'd2, 7'd44, 4'd7, 32'h100, 32'h2000, 1'b1, 1'b1);
        bus.issue_en = 1'b0;
      end
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        if (bus.wb_valid) begin
          if (first < 0) first = k;
          last = k;
          got.push_back(bus.wb_data);
        end
      end
    join
    chk("b2b_count", got.size(), 4);
    chk("b2b_consecutive", last - first, 3);
    if (got.size() == 4) begin
      chk("b2b_sub", got[0], 32'h12);
      chk("b2b_slt", got[1], 32'h1);
      chk("b2b_sra", got[2], 32'hF8000000);
      chk("b2b_auipc", got[3], 32'h2100);
    end
    @(posedge clk); #1;
    // backpressure
    bus.wb_ready = 1'b0;
    rand_fields();
    bus.issue_en = 1'b1;
    acc = 0;
    snap = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acc += int'(bus.eu_ready);
      if (k == 3) snap = bus.wb_data;
      if (k == 4) chk("bp_stable", bus.wb_data, snap);
      @(posedge clk); #1;
      rand_fields();
    end
    chk("bp_accepts", acc, 3);
    bus.issue_en = 1'b0;
    bus.wb_ready = 1'b1;
    drain();
    // prd = 0
    issue(4'd0, 7'd5, 7'd6, 7'd0, 4'd2, 0, 0, 1'b0, 1'b1);
    bus.issue_en = 1'b0;
    lat_check("prd0_latency");
    chk("prd0_reg_write", bus.wb_reg_write, 0);
    @(posedge clk); #1;
    // flush with three in flight plus a colliding issue
    for (int k = 0; k < 3; k++) rand_issue();
    rand_fields();
    bus.flush = 1'b1;
    bus.issue_en = 1'b1;
    @(negedge clk);
    chk("flush_eu_ready", bus.eu_ready, 0);
    chk("flush_wb_en", bus.wb_en, 1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.issue_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_no_wb", bus.wb_valid, 0);
      if (k == 0) chk("flush_ready_after", bus.eu_ready, 1);
    end
    @(posedge clk); #1;
    // async reset mid-stream
    bus.wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) rand_issue();
    bus.issue_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", bus.wb_valid, 0);
    chk("arst_wb_fields", {bus.wb_prd, bus.wb_data, bus.wb_rob_tag, bus.wb_reg_write, bus.wb_en}, 0);
    chk("arst_raddr", {bus.prf_raddr1, bus.prf_raddr2}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    issue(4'd0, 7'd5, 7'd6, 7'd12, 4'd9, 0, 0, 1'b0, 1'b1);
    bus.issue_en = 1'b0;
    lat_check("arst_latency");
    chk("arst_data", bus.wb_data, 32'h32);
    @(posedge clk); #1;
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rand_fields();
      bus.issue_en = ($urandom_range(0, 9) < 7);
      bus.wb_ready = ($urandom_range(0, 9) < 7);
      bus.flush = ($urandom_range(0, 99) < 3);
      @(posedge clk); #1;
    end
    bus.issue_en = 1'b0;
    bus.flush = 1'b0;
    bus.wb_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
Integer execution unit directly downstream of the ALU reservation station. It accepts one issued entry per cycle via the issue_en/eu_ready handshake and reads operands from the physical register file. It computes the result over a 3-stage pipeline (RR, EX, WB). It presents the result to the CDB/writeback arbiter with a valid/ready handshake, and its accepted writeback drives the RS wakeup (wb_en/wb_prd).

Parameters:
PHYS_REG_BITS, 7, physical register index width
ROB_TAG_BITS, 4, ROB tag width
XLEN, 32, datapath width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
issue_en  in  1  RS presents a valid entry
eu_ready  out  1  unit can accept an entry this cycle
issue_prs1  in  PHYS_REG_BITS  source 1 physical register
issue_prs2  in  PHYS_REG_BITS  source 2 physical register
issue_prd  in  PHYS_REG_BITS  destination physical register
issue_rob_tag  in  ROB_TAG_BITS  ROB tag
issue_pc  in  XLEN  instruction PC
issue_imm  in  XLEN  immediate
issue_alu_src  in  1  1 = operand B is the immediate
issue_alu_ctrl  in  4  operation code (see Behaviour)
issue_reg_write  in  1  destination is written
prf_raddr1  out  PHYS_REG_BITS  PRF read port 1 address
prf_raddr2  out  PHYS_REG_BITS  PRF read port 2 address
prf_rdata1  in  XLEN  PRF read data 1 (combinational)
prf_rdata2  in  XLEN  PRF read data 2 (combinational)
wb_valid  out  1  result available
wb_ready  in  1  arbiter accepts result
wb_prd  out  PHYS_REG_BITS  result destination
wb_data  out  XLEN  result value
wb_rob_tag  out  ROB_TAG_BITS  result ROB tag
wb_reg_write  out  1  PRF write enable qualifier
wb_en  out  1  wakeup pulse = wb_valid & wb_ready
flush  in  1  squash all in-flight entries

Behaviour:
- Stage valids: rr_v, ex_v, wb_v. wb_valid = wb_v.
- Reset (rst_n low, asynchronous): all valids 0. wb_valid, wb_en, wb_prd, wb_data, wb_rob_tag, wb_reg_write and prf_raddr* = 0. eu_ready = 1 once rst_n deasserts.
- Reset asserted mid-operation drops all in-flight entries immediately. No writeback is produced for them.
- Stall chain: adv_wb = !wb_v | wb_ready; adv_ex = !ex_v | adv_wb; adv_rr = !rr_v | adv_ex.
- eu_ready = adv_rr & !flush. It is combinational, so it does not depend on issue_en.
- Accept: issue_en & eu_ready at edge N captures the entry into the RR register.
- RR stage (cycle N+1): prf_raddr1/2 = rr prs1/prs2. When adv_ex, the operands and control are latched into the EX register at edge N+1.
- EX stage (cycle N+2): combinational ALU. A = rs1; B = alu_src ? imm : rs2. The result is latched into the WB register at edge N+2 when adv_wb.
- WB stage: wb_valid is high in cycle N+3 (no stalls). It holds all wb_* outputs stable until wb_ready. Minimum issue-to-wb_valid latency is 3 cycles. Throughput is 1 entry/cycle.
- A stalled stage holds its contents. A bubble is inserted behind a stage that advances with nothing behind it.
- alu_ctrl encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 LUI (result = B), 11 AUIPC (result = pc + imm)
  - 12-15 produce 0
  - Shift amount = B[4:0]. Arithmetic wraps modulo 2^XLEN. SLT/SLTU yield 0 or 1.
- wb_reg_write = latched reg_write & (prd != 0). wb_valid is still asserted when prd = 0 so the ROB completes.
- wb_en = wb_valid & wb_ready. wb_prd doubles as the RS wakeup tag.
- Flush:
  - At the edge where flush = 1, rr_v/ex_v/wb_v all clear. wb_valid is 0 the following cycle.
  - An issue presented in the flush cycle is not accepted (eu_ready = 0).
  - A wb handshake occurring in the flush cycle still counts: wb_en is high that cycle.
- Simultaneous events: wb accept plus new issue in the same cycle with a full pipe is legal. All stages shift, and eu_ready stays 1.

Test Plan:
- Single op: issue ADD, prs1 = 5 (data 0x10), prs2 = 6 (data 0x22), prd = 40, tag = 3, wb_ready = 1 -> wb_valid exactly 3 cycles after accept with wb_data = 0x32, wb_prd = 40, wb_rob_tag = 3, wb_en = 1 for one cycle.
- Back-to-back: 4 issues on consecutive cycles (SUB, SLT signed 0xFFFFFFFF vs 1, SRA 0x80000000 by 4, AUIPC pc = 0x100 imm = 0x2000) -> 4 consecutive wb_valid cycles with results 0x…, 1, 0xF8000000, 0x2100, in order.
- Backpressure: wb_ready = 0 for 5 cycles while issuing continuously -> eu_ready drops after 3 accepts, wb outputs stay stable; on release wb_ready = 1 -> results drain in order, nothing dropped or duplicated.
- prd = 0 with reg_write = 1 -> wb_valid = 1, wb_reg_write = 0.
- Flush with 3 entries in flight plus issue_en in the same cycle -> no wb_valid afterward, issue not accepted, eu_ready = 1 next cycle.
- Async reset mid-stream: rst_n low between clock edges -> wb_valid drops immediately, all outputs 0; after release the first new issue produces its result at +3 cycles.
